// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI-to-SRAM slave.
package axi_sram_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_READ,
    ST_WRITE,
    ST_WRESP
  } state_e;

endpackage

// File: rtl/axi_sram_slave_sram_port_mux.sv
// Drives the single SRAM port from either the read path or the write path.
module sram_port_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 14
) (
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [MEM_AW-1:0]     rd_addr,
  input  logic [MEM_AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic                  CEB,
  output logic                  WEB,
  output logic [DATA_W-1:0]     BWEB,
  output logic [MEM_AW-1:0]     A,
  output logic [DATA_W-1:0]     DI
);

  // Write beats take priority; otherwise a read cycle or an idle, deselected port.
  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = '1;
    A    = wr_addr;
    DI   = '0;
    if (wr_en) begin
      CEB = 1'b0;
      WEB = 1'b0;
      DI  = wdata;
      for (int unsigned i = 0; i < DATA_W/8; i++) begin
        BWEB[8*i +: 8] = {8{~wstrb[i]}};
      end
    end else if (rd_en) begin
      CEB = 1'b0;
      A   = rd_addr;
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave mapping one read or write burst at a time onto a single-port synchronous SRAM.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned MEM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                CEB,
  output logic                WEB,
  output logic [DATA_W-1:0]   BWEB,
  output logic [MEM_AW-1:0]   A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [MEM_AW-1:0] addr_q, addr_adv, rd_addr;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic              fixed_q, err_q, rd_pri_q;
  logic              last_beat, both_req, ar_acc, aw_acc, rd_beat, wr_beat;
  logic              rd_en, wr_en;
  logic              unused_inputs;

  // Size is always treated as a full word; byte offset and high address bits are ignored.
  assign unused_inputs = ^{ARSIZE, AWSIZE, ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0],
                           AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0]};

  assign last_beat = (cnt_q == len_q);
  assign addr_adv  = fixed_q ? addr_q : addr_q + MEM_AW'(1);
  assign both_req  = ARVALID & AWVALID;
  assign ar_acc    = ARVALID & ARREADY;
  assign aw_acc    = AWVALID & AWREADY;
  assign rd_beat   = (state_q == ST_READ) & RREADY;
  assign wr_beat   = (state_q == ST_WRITE) & WVALID;

  assign RID   = id_q;
  assign BID   = id_q;
  assign RDATA = DO;
  assign RRESP = RESP_OKAY;
  assign RLAST = (state_q == ST_READ) & last_beat;
  assign BRESP = err_q ? RESP_SLVERR : RESP_OKAY;

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake outputs and SRAM request selection.
  // During a read handshake the next address is presented early so beats stream back to back;
  // while stalled the current address is re-read so DO stays stable.
  always_comb begin
    state_d = state_q;
    ARREADY = 1'b0;
    AWREADY = 1'b0;
    RVALID  = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      ST_IDLE: begin
        ARREADY = ~ARESET & (~both_req | rd_pri_q);
        AWREADY = ~ARESET & (~both_req | ~rd_pri_q);
        if (ARVALID && ARREADY)      state_d = ST_RD_ADDR;
        else if (AWVALID && AWREADY) state_d = ST_WRITE;
      end
      ST_RD_ADDR: begin
        rd_en   = 1'b1;
        state_d = ST_READ;
      end
      ST_READ: begin
        RVALID = 1'b1;
        rd_en  = 1'b1;
        if (RREADY) begin
          rd_addr = addr_adv;
          if (last_beat) state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        WREADY = 1'b1;
        if (WVALID) begin
          wr_en = 1'b1;
          if (last_beat) state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        BVALID = 1'b1;
        if (BREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction context: latched on accept, advanced per beat; grant priority toggles on each accept.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_pri_q <= 1'b1;
    end else if (ar_acc) begin
      id_q     <= ARID;
      addr_q   <= ARADDR[MEM_AW+1:2];
      len_q    <= ARLEN;
      fixed_q  <= (ARBURST == BURST_FIXED);
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_pri_q <= 1'b0;
    end else if (aw_acc) begin
      id_q     <= AWID;
      addr_q   <= AWADDR[MEM_AW+1:2];
      len_q    <= AWLEN;
      fixed_q  <= (AWBURST == BURST_FIXED);
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_pri_q <= 1'b1;
    end else if (rd_beat || wr_beat) begin
      cnt_q  <= cnt_q + LEN_W'(1);
      addr_q <= addr_adv;
      if (wr_beat && (WLAST != last_beat)) err_q <= 1'b1;
    end
  end

  sram_port_mux #(
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW)
  ) u_mux (
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .wr_addr (addr_q),
    .wdata   (WDATA),
    .wstrb   (WSTRB),
    .CEB     (CEB),
    .WEB     (WEB),
    .BWEB    (BWEB),
    .A       (A),
    .DI      (DI)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural synchronous SRAM.
`timescale 1ns/1ps
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  logic        ACLK, ARESET;
  logic [7:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA, BWEB, DI, DO;
  logic [3:0]  ARLEN, AWLEN, WSTRB;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        CEB, WEB;
  logic [13:0] A;

  axi_sram_slave #(
    .ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .MEM_AW(14)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Synchronous SRAM: DO valid one cycle after a read; word i preloads to {16'hA5A5, i}.
  logic        mem_load;
  logic [31:0] mem [0:16383];
  always @(posedge ACLK) begin
    if (mem_load) begin
      for (int i = 0; i < 16384; i++) mem[i] <= {16'hA5A5, 16'(i)};
    end else if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
      else      DO <= mem[A];
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] exp_d [16];
  logic [13:0] cap_a [16];
  logic [31:0] cap_bweb [16];
  logic [31:0] cap_di [16];
  logic [1:0]  got_bresp;
  logic [7:0]  got_bid;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [13:0] exp_a;
    logic [31:0] exp_bweb;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    int unsigned n;
    n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'b010; ARBURST = burst; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("ar handshake", 32'(ARREADY), 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    int unsigned n;
    n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'b010; AWBURST = burst; AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("aw handshake", 32'(AWREADY), 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  // Write burst from wd/ws; WLAST on beat wlast_at (or on the true last beat if negative);
  // one idle cycle inserted after beat gap_after (none if negative).
  task automatic wr_burst(input string nm, input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input int wlast_at, input int gap_after);
    aw_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = ws[i];
      WLAST = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
      WVALID = 1'b1;
      @(negedge ACLK);
      chk({nm, " wready"}, 32'(WREADY), 1);
      chk({nm, " ceb"}, 32'(CEB), 0);
      chk({nm, " web"}, 32'(WEB), 0);
      cap_a[i] = A; cap_bweb[i] = BWEB; cap_di[i] = DI;
      @(posedge ACLK); #1;
      WVALID = 1'b0; WLAST = 1'b0;
      if (i == gap_after) begin
        @(negedge ACLK);
        chk({nm, " gap ceb"}, 32'(CEB), 1);
        @(posedge ACLK); #1;
      end
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    chk({nm, " bvalid"}, 32'(BVALID), 1);
    got_bresp = BRESP; got_bid = BID;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  // Read burst checked against exp_d; RREADY follows bit (cycle % 16) of rr_pat.
  task automatic rd_burst(input string nm, input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input logic [15:0] rr_pat, input int exp_cyc);
    int beat, cyc;
    beat = 0; cyc = 0;
    ar_send(id, addr, len, burst);
    @(negedge ACLK);
    chk({nm, " rvalid in addr phase"}, 32'(RVALID), 0);
    @(posedge ACLK); #1;
    while (beat <= int'(len) && cyc < 40) begin
      RREADY = rr_pat[cyc % 16];
      @(negedge ACLK);
      chk({nm, " rvalid"}, 32'(RVALID), 1);
      if (RVALID) begin
        chk($sformatf("%s rdata b%0d", nm, beat), RDATA, exp_d[beat]);
        chk({nm, " rid"}, 32'(RID), 32'(id));
        chk({nm, " rresp"}, 32'(RRESP), 0);
        chk($sformatf("%s rlast b%0d", nm, beat), 32'(RLAST), 32'(beat == int'(len)));
        if (RREADY) beat++;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    RREADY = 1'b0;
    chk({nm, " beats"}, 32'(beat), 32'(int'(len) + 1));
    chk({nm, " cycles"}, 32'(cyc), 32'(exp_cyc));
    @(negedge ACLK);
    chk({nm, " rvalid after last"}, 32'(RVALID), 0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b0101, 14'h0004,  32'hFF00_FF00, 32'hA5AD_00EF};
    tbl[1] = '{32'h0000_0020, 32'h1234_5678, 4'b1111, 14'h0008,  32'h0000_0000, 32'h1234_5678};
    tbl[2] = '{32'h0000_003C, 32'hCAFE_F00D, 4'b1000, 14'h000F,  32'h00FF_FFFF, 32'hCAA5_000F};
    tbl[3] = '{32'h0001_FFFC, 32'h0000_0000, 4'b0010, 14'h3FFF,  32'hFFFF_00FF, 32'hA5A5_00FF};
    tbl[4] = '{32'h0000_0012, 32'h1122_3344, 4'b0010, 14'h0004,  32'hFFFF_00FF, 32'hA5AD_33EF};
    tbl[5] = '{32'h0000_0040, 32'h55AA_55AA, 4'b0000, 14'h0010,  32'hFFFF_FFFF, 32'hA5A5_0010};

    // Reset with every input high.
    ARESET = 1'b1; mem_load = 1'b1;
    ARID = '1; ARADDR = '1; ARLEN = '1; ARSIZE = '1; ARBURST = '1; ARVALID = 1'b1; RREADY = 1'b1;
    AWID = '1; AWADDR = '1; AWLEN = '1; AWSIZE = '1; AWBURST = '1; AWVALID = 1'b1;
    WDATA = '1; WSTRB = '1; WLAST = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 mem_load = 1'b0;
    @(negedge ACLK);
    chk("rst arready", 32'(ARREADY), 0);
    chk("rst awready", 32'(AWREADY), 0);
    chk("rst rvalid", 32'(RVALID), 0);
    chk("rst wready", 32'(WREADY), 0);
    chk("rst bvalid", 32'(BVALID), 0);
    chk("rst rlast", 32'(RLAST), 0);
    chk("rst rresp", 32'(RRESP), 0);
    chk("rst bresp", 32'(BRESP), 0);
    chk("rst ceb", 32'(CEB), 1);
    chk("rst web", 32'(WEB), 1);
    chk("rst bweb", BWEB, 32'hFFFF_FFFF);
    chk("rst a", 32'(A), 0);
    chk("rst di", DI, 0);
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0; BREADY = 1'b0;
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("post-rst arready", 32'(ARREADY), 1);
    chk("post-rst awready", 32'(AWREADY), 1);
    @(posedge ACLK); #1;

    // Single-beat write/read-back table.
    for (int k = 0; k < 6; k++) begin
      wd[0] = tbl[k].wdata; ws[0] = tbl[k].wstrb;
      wr_burst($sformatf("v%0d wr", k), 8'(8'h10 + k), tbl[k].addr, 4'd0, BURST_INCR, -1, -1);
      chk($sformatf("v%0d a", k), 32'(cap_a[0]), 32'(tbl[k].exp_a));
      chk($sformatf("v%0d bweb", k), cap_bweb[0], tbl[k].exp_bweb);
      chk($sformatf("v%0d di", k), cap_di[0], tbl[k].wdata);
      chk($sformatf("v%0d bresp", k), 32'(got_bresp), 0);
      chk($sformatf("v%0d bid", k), 32'(got_bid), 32'(8'h10 + k));
      exp_d[0] = tbl[k].exp_rd;
      rd_burst($sformatf("v%0d rd", k), 8'(8'h20 + k), tbl[k].addr, 4'd0, BURST_INCR, 16'hFFFF, 1);
    end

    // INCR write burst with an idle cycle, then full-rate, stalled and FIXED reads.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB000_0000 | 32'(i); ws[i] = 4'hF; end
    wr_burst("incr wr", 8'h30, 32'h100, 4'd3, BURST_INCR, -1, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("incr wr a%0d", i), 32'(cap_a[i]), 32'(14'h40 + i));
    chk("incr wr bresp", 32'(got_bresp), 0);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hB000_0000 | 32'(i);
    rd_burst("incr rd", 8'h31, 32'h100, 4'd3, BURST_INCR, 16'hFFFF, 4);
    rd_burst("stall rd", 8'h32, 32'h100, 4'd3, BURST_INCR, 16'h9999, 8);
    for (int i = 0; i < 3; i++) exp_d[i] = 32'hB000_0000;
    rd_burst("fixed rd", 8'h33, 32'h100, 4'd2, BURST_FIXED, 16'hFFFF, 3);

    // Early WLAST: burst still runs LEN+1 beats, response is SLVERR.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h0000_0600 + 32'(i); ws[i] = 4'hF; end
    wr_burst("wlast err", 8'h66, 32'h200, 4'd3, BURST_INCR, 1, -1);
    chk("wlast err bresp", 32'(got_bresp), 32'(RESP_SLVERR));
    chk("wlast err bid", 32'(got_bid), 32'h66);
    chk("wlast err a3", 32'(cap_a[3]), 32'h83);

    // Simultaneous AR and AW twice: read granted first, then write.
    ARID = 8'h51; ARADDR = 32'h20; ARLEN = 4'd0; ARSIZE = 3'b000; ARBURST = BURST_INCR; ARVALID = 1'b1;
    AWID = 8'h61; AWADDR = 32'h80; AWLEN = 4'd0; AWSIZE = 3'b001; AWBURST = BURST_INCR; AWVALID = 1'b1;
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("arb1 arready", 32'(ARREADY), 1);
    chk("arb1 awready", 32'(AWREADY), 0);
    @(posedge ACLK); #1 ARID = 8'h52;
    @(negedge ACLK);
    chk("arb busy arready", 32'(ARREADY), 0);
    chk("arb busy awready", 32'(AWREADY), 0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("arb rd rvalid", 32'(RVALID), 1);
    chk("arb rd rdata", RDATA, 32'h1234_5678);
    chk("arb rd rid", 32'(RID), 32'h51);
    chk("arb rd rlast", 32'(RLAST), 1);
    @(posedge ACLK); #1 RREADY = 1'b0;
    @(negedge ACLK);
    chk("arb2 awready", 32'(AWREADY), 1);
    chk("arb2 arready", 32'(ARREADY), 0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0; AWVALID = 1'b0;
    WDATA = 32'h0BAD_F00D; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    chk("arb wr wready", 32'(WREADY), 1);
    chk("arb wr a", 32'(A), 32'h20);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    chk("arb wr bvalid", 32'(BVALID), 1);
    chk("arb wr bid", 32'(BID), 32'h61);
    chk("arb wr bresp", 32'(BRESP), 0);
    @(posedge ACLK); #1 BREADY = 1'b0;
    exp_d[0] = 32'h0BAD_F00D;
    rd_burst("arb readback", 8'h62, 32'h80, 4'd0, BURST_INCR, 16'hFFFF, 1);

    // Reset in the middle of a read burst.
    ar_send(8'h77, 32'h100, 4'd3, BURST_INCR);
    @(posedge ACLK); #1 RREADY = 1'b1;
    @(negedge ACLK);
    chk("mid-rst b0", RDATA, 32'hB000_0000);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("mid-rst b1", RDATA, 32'hB000_0001);
    #2 ARESET = 1'b1;
    #1;
    chk("mid-rst rvalid", 32'(RVALID), 0);
    chk("mid-rst ceb", 32'(CEB), 1);
    @(posedge ACLK); #1 ARESET = 1'b0; RREADY = 1'b0;
    @(negedge ACLK);
    chk("after rst rvalid", 32'(RVALID), 0);
    chk("after rst arready", 32'(ARREADY), 1);
    chk("after rst awready", 32'(AWREADY), 1);
    @(posedge ACLK); #1;
    exp_d[0] = 32'h1234_5678;
    rd_burst("after rst rd", 8'h78, 32'h20, 4'd0, BURST_INCR, 16'hFFFF, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
